// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader. It takes a byte stream (count, big-endian
//               16-bit words, XOR checksum), writes the words into instruction
//               memory from address 0, and raises cpu_run once the checksum
//               matches.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_run,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // State encoding
  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_hi   = 3'd1;
  localparam logic [2:0] c_lo   = 3'd2;
  localparam logic [2:0] c_chk  = 3'd3;
  localparam logic [2:0] c_done = 3'd4;
  localparam logic [2:0] c_err  = 3'd5;

  // A count byte of zero stands for a full memory image of 2^ADDR_W words
  localparam logic [ADDR_W:0] c_full = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_one  = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic              w_ready;
  logic              w_xfer;
  logic [ADDR_W:0]   w_count_ext;

  logic [7:0]        r_acc;
  logic [7:0]        r_hi;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic              r_cpu_run;
  logic              r_err;

  assign w_xfer      = in_valid && w_ready;
  assign w_count_ext = (in_data == 8'd0) ? c_full : (ADDR_W+1)'(in_data);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; every transition is gated by a byte transfer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: if (w_xfer) w_next_state = c_hi;
      c_hi:   if (w_xfer) w_next_state = c_lo;
      c_lo:   if (w_xfer) w_next_state = (r_remaining == c_one) ? c_chk : c_hi;
      c_chk:  if (w_xfer) w_next_state = (in_data == r_acc) ? c_done : c_err;
      c_done: w_next_state = c_done;
      c_err:  w_next_state = c_err;
      default: w_next_state = c_idle;
    endcase
  end

  // Output decode: bytes are accepted in every non-terminal state
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      c_idle, c_hi, c_lo, c_chk: w_ready = 1'b1;
      default:                   w_ready = 1'b0;
    endcase
  end

  // Datapath: checksum, word assembly, counters, memory write port and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= 8'd0;
      r_hi        <= 8'd0;
      r_remaining <= '0;
      r_count     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cpu_run   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse
      r_wr_en <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          c_idle: begin
            r_remaining <= w_count_ext;
            r_count     <= '0;
            r_acc       <= in_data;
          end
          c_hi: begin
            r_hi  <= in_data;
            r_acc <= r_acc ^ in_data;
          end
          c_lo: begin
            r_acc       <= r_acc ^ in_data;
            r_wr_en     <= 1'b1;
            r_wr_addr   <= r_count[ADDR_W-1:0];
            r_wr_data   <= WORD_W'({r_hi, in_data});
            // Counter is one bit wider than the address, so 256 words do not wrap
            r_count     <= r_count + c_one;
            r_remaining <= r_remaining - c_one;
          end
          c_chk: begin
            if (in_data == r_acc) begin
              r_cpu_run <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign in_ready     = w_ready;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign cpu_run      = r_cpu_run;
  assign err          = r_err;
  assign words_loaded = r_count;

`ifndef SYNTHESIS
  // Run and error are mutually exclusive outcomes of the checksum test
  a_run_err_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(r_cpu_run && r_err));
  // Two bytes per word means writes can never be on adjacent cycles
  a_wr_single : assert property (@(posedge clk) disable iff (!rst_n)
    r_wr_en |=> !r_wr_en);
  // The word counter tops out at a full memory image
  a_count_max : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= c_full);
`endif

endmodule
`default_nettype wire
